sevenseg_scan: RTL and testbench

Downstream consumer of the stopwatch counter's four BCD digits (d3 = most significant … d0 = least significant). It time-multiplexes the Basys3 4-digit common-anode seven-segment display. The block does the following:
- Captures a tear-free snapshot of the digits once per frame.
- Scans one anode at a time at a fixed refresh rate.
- Decodes BCD to active-low cathodes, with leading-zero blanking, a fixed decimal point, and an invalid-code indication.

---
 rtl/sevenseg_scan.sv | 98 +++++++++
 tb/tb_sevenseg_scan.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Snapshots the BCD digits once per frame and decodes with leading-zero blanking.
module sevenseg_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DP_DIGIT    = 2,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] TERM   = PW'(REFRESH_DIV - 1);
  localparam logic [1:0]    DP_SEL = 2'(DP_DIGIT);

  logic [PW-1:0]    prescaler;
  logic [1:0]       idx;
  logic [3:0][3:0]  shadow;

  logic             tick;
  logic [1:0]       idx_nx;
  logic [3:0][3:0]  shadow_nx;
  logic [3:0]       digit;
  logic [3:0]       zero_from;
  logic [3:0]       lz_mask;
  logic             blank;
  logic [6:0]       seg_dec;
  logic [3:0]       an_nx;
  logic [6:0]       seg_nx;
  logic             dp_nx;

  always_comb begin
    tick   = (prescaler == TERM);
    idx_nx = idx + 2'd1;
    // Decode from the snapshot being taken on the wrap, so digit 0 of a
    // frame already shows the freshly captured value.
    shadow_nx = (idx == 2'd3) ? {d3, d2, d1, d0} : shadow;
    digit     = shadow_nx[idx_nx];

    zero_from[3] = (shadow_nx[3] == 4'd0);
    zero_from[2] = zero_from[3] && (shadow_nx[2] == 4'd0);
    zero_from[1] = zero_from[2] && (shadow_nx[1] == 4'd0);
    zero_from[0] = zero_from[1] && (shadow_nx[0] == 4'd0);

    lz_mask = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      lz_mask[k] = BLANK_LZ && (k > DP_DIGIT);
    end
    blank = lz_mask[idx_nx] && zero_from[idx_nx];

    case (digit)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase

    seg_nx = blank ? 7'h7F : seg_dec;
    an_nx  = en ? ~(4'b0001 << idx_nx) : 4'b1111;
    dp_nx  = ~(en && (idx_nx == DP_SEL));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      idx       <= 2'd3;
      shadow    <= '0;
      an        <= '1;
      seg       <= '1;
      dp        <= 1'b1;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        idx    <= idx_nx;
        shadow <= shadow_nx;
        an     <= an_nx;
        seg    <= seg_nx;
        dp     <= dp_nx;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with REFRESH_DIV=4, DP_DIGIT=2; a second
// instance with leading-zero blanking disabled shares all inputs.
module tb_sevenseg_scan;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] an, an_nb;
  logic [6:0] seg, seg_nb;
  logic       dp, dp_nb;

  int unsigned tests;
  int unsigned fails;
  int unsigned cyc;

  sevenseg_scan #(.REFRESH_DIV(4), .DP_DIGIT(2), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .reset(reset), .en(en),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .an(an), .seg(seg), .dp(dp)
  );

  sevenseg_scan #(.REFRESH_DIV(4), .DP_DIGIT(2), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .reset(reset), .en(en),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .an(an_nb), .seg(seg_nb), .dp(dp_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [6:0]  seg_nb;
    bit          load;
    logic [15:0] digits;  // {d3,d2,d1,d0} applied after this check
  } vec_t;

  vec_t tab[23];

  task automatic step_to(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic set_digits(input logic [15:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  task automatic check(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp, input bit seg_care, input logic [6:0] e_nb);
    tests++;
    if (an !== e_an || dp !== e_dp || an_nb !== e_an || dp_nb !== e_dp ||
        (seg_care && (seg !== e_seg || seg_nb !== e_nb))) begin
      fails++;
      $display("FAIL %s @cyc %0d: an=%b seg=%h dp=%b an_nb=%b seg_nb=%h dp_nb=%b; expected an=%b seg=%h dp=%b seg_nb=%h (seg checked=%0d)",
               name, cyc, an, seg, dp, an_nb, seg_nb, dp_nb, e_an, e_seg, e_dp, e_nb, seg_care);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;

    tab[0]  = '{1,  4'b1111, 7'h7F, 1'b1, 7'h7F, 1'b0, 16'h0000};
    tab[1]  = '{3,  4'b1111, 7'h7F, 1'b1, 7'h7F, 1'b0, 16'h0000};
    tab[2]  = '{4,  4'b1110, 7'h19, 1'b1, 7'h19, 1'b0, 16'h0000};
    tab[3]  = '{7,  4'b1110, 7'h19, 1'b1, 7'h19, 1'b0, 16'h0000};
    tab[4]  = '{8,  4'b1101, 7'h30, 1'b1, 7'h30, 1'b0, 16'h0000};
    tab[5]  = '{12, 4'b1011, 7'h24, 1'b0, 7'h24, 1'b0, 16'h0000};
    tab[6]  = '{16, 4'b0111, 7'h79, 1'b1, 7'h79, 1'b1, 16'h0005};
    tab[7]  = '{20, 4'b1110, 7'h12, 1'b1, 7'h12, 1'b0, 16'h0000};
    tab[8]  = '{24, 4'b1101, 7'h40, 1'b1, 7'h40, 1'b0, 16'h0000};
    tab[9]  = '{28, 4'b1011, 7'h40, 1'b0, 7'h40, 1'b0, 16'h0000};
    tab[10] = '{32, 4'b0111, 7'h7F, 1'b1, 7'h40, 1'b1, 16'h0004};
    tab[11] = '{36, 4'b1110, 7'h19, 1'b1, 7'h19, 1'b0, 16'h0000};
    tab[12] = '{40, 4'b1101, 7'h40, 1'b1, 7'h40, 1'b1, 16'h7009};
    tab[13] = '{44, 4'b1011, 7'h40, 1'b0, 7'h40, 1'b0, 16'h0000};
    tab[14] = '{48, 4'b0111, 7'h7F, 1'b1, 7'h40, 1'b0, 16'h0000};
    tab[15] = '{52, 4'b1110, 7'h10, 1'b1, 7'h10, 1'b0, 16'h0000};
    tab[16] = '{64, 4'b0111, 7'h78, 1'b1, 7'h78, 1'b1, 16'h00C0};
    tab[17] = '{68, 4'b1110, 7'h40, 1'b1, 7'h40, 1'b0, 16'h0000};
    tab[18] = '{72, 4'b1101, 7'h3F, 1'b1, 7'h3F, 1'b0, 16'h0000};
    tab[19] = '{76, 4'b1011, 7'h40, 1'b0, 7'h40, 1'b0, 16'h0000};
    tab[20] = '{80, 4'b0111, 7'h7F, 1'b1, 7'h40, 1'b1, 16'hC000};
    tab[21] = '{84, 4'b1110, 7'h40, 1'b1, 7'h40, 1'b0, 16'h0000};
    tab[22] = '{96, 4'b0111, 7'h3F, 1'b1, 7'h3F, 1'b0, 16'h0000};

    reset = 1'b0;
    en    = 1'b1;
    set_digits(16'h1234);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 4'b1111, 7'h7F, 1'b1, 1'b1, 7'h7F);
    #2 reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step_to(tab[i].cyc);
      check($sformatf("vec%0d", i), tab[i].an, tab[i].seg, tab[i].dp, 1'b1, tab[i].seg_nb);
      if (tab[i].load) set_digits(tab[i].digits);
    end

    // Enable drop: takes effect at the next tick, scan keeps advancing.
    step_to(98);
    en = 1'b0;
    step_to(99);
    check("en_off_not_immediate", 4'b0111, 7'h3F, 1'b1, 1'b1, 7'h3F);
    step_to(100);
    check("en_off_dig0", 4'b1111, 7'h00, 1'b1, 1'b0, 7'h00);
    step_to(104);
    check("en_off_dig1", 4'b1111, 7'h00, 1'b1, 1'b0, 7'h00);
    step_to(108);
    check("en_off_dp_digit", 4'b1111, 7'h00, 1'b1, 1'b0, 7'h00);
    step_to(110);
    en = 1'b1;
    step_to(111);
    check("en_on_not_immediate", 4'b1111, 7'h00, 1'b1, 1'b0, 7'h00);
    step_to(112);
    check("en_on_dig3", 4'b0111, 7'h3F, 1'b1, 1'b1, 7'h3F);

    // Asynchronous reset between clock edges.
    step_to(114);
    #2 reset = 1'b0;
    #1;
    check("async_reset_dark", 4'b1111, 7'h7F, 1'b1, 1'b1, 7'h7F);
    #3 reset = 1'b1;
    cyc = 0;
    step_to(1);
    check("rerst_cyc1", 4'b1111, 7'h7F, 1'b1, 1'b1, 7'h7F);
    step_to(3);
    check("rerst_cyc3", 4'b1111, 7'h7F, 1'b1, 1'b1, 7'h7F);
    step_to(4);
    check("rerst_first_dig0", 4'b1110, 7'h40, 1'b1, 1'b1, 7'h40);
    step_to(12);
    check("rerst_dig2", 4'b1011, 7'h40, 1'b0, 1'b1, 7'h40);
    step_to(16);
    check("rerst_dig3_invalid", 4'b0111, 7'h3F, 1'b1, 1'b1, 7'h3F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
